// File: rtl/boot_loader_ctrl_if.sv
// Bus bundle for boot_loader_ctrl: UART FIFO handshakes, imem write port,
// core-side requests and core release. master = loader, slave = surroundings.
`timescale 1ns/1ps
interface boot_loader_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        uart_rx_data;
  logic              empty;
  logic              uart_rd_en;
  logic [7:0]        uart_tx_data;
  logic              full;
  logic              uart_wr_en;
  logic              cpu_uart_rd_en;
  logic [7:0]        cpu_uart_tx_data;
  logic              cpu_uart_wr_en;
  logic              cpu_imem_we;
  logic [ADDR_W-1:0] cpu_imem_waddr;
  logic [31:0]       cpu_imem_di;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_di;
  logic              cpu_rstn;
  logic              done;

  modport master (
    input  uart_rx_data, empty, full,
    input  cpu_uart_rd_en, cpu_uart_tx_data, cpu_uart_wr_en,
    input  cpu_imem_we, cpu_imem_waddr, cpu_imem_di,
    output uart_rd_en, uart_tx_data, uart_wr_en,
    output imem_we, imem_waddr, imem_di, cpu_rstn, done
  );

  modport slave (
    output uart_rx_data, empty, full,
    output cpu_uart_rd_en, cpu_uart_tx_data, cpu_uart_wr_en,
    output cpu_imem_we, cpu_imem_waddr, cpu_imem_di,
    input  uart_rd_en, uart_tx_data, uart_wr_en,
    input  imem_we, imem_waddr, imem_di, cpu_rstn, done
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: loads a length-prefixed image from UART into imem, acks, then
// hands imem/UART to the core. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module boot_loader_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  NAK_BYTE = 8'h55
) (
  input logic                clk,
  input logic                rst,
  boot_loader_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_ACK,
    S_RUN
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = S_CSUM;
`else
  localparam state_t POST_DATA = S_ACK;
`endif

  state_t            state;
  logic [1:0]        byteCnt;
  logic [23:0]       asmBytes;
  logic [31:0]       wordLen;
  logic [31:0]       wordIdx;
  logic              imemWeR;
  logic [ADDR_W-1:0] imemAddrR;
  logic [31:0]       imemDiR;
  logic              ackArm;
  logic              cpuRstnR;
  logic              doneR;
  logic              ackOk;
  logic              intake;
  logic              pop;
  logic              running;
  logic [31:0]       word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csumOk;
  assign ackOk = csumOk;
`else
  assign ackOk = 1'b1;
`endif

  always_comb begin
    intake = (state == S_LEN) || (state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state == S_CSUM) intake = 1'b1;
`endif
  end

  // A pop during rst would lose a byte the restarted load never sees.
  assign pop     = intake && !bus.empty && !rst;
  assign running = (state == S_RUN);
  assign word    = {asmBytes, bus.uart_rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN;
      byteCnt   <= '0;
      asmBytes  <= '0;
      wordLen   <= '0;
      wordIdx   <= '0;
      imemWeR   <= 1'b0;
      imemAddrR <= '0;
      imemDiR   <= '0;
      ackArm    <= 1'b0;
      cpuRstnR  <= 1'b0;
      doneR     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
      csumOk    <= 1'b0;
`endif
    end else begin
      imemWeR <= 1'b0;
      if (pop) begin
        byteCnt  <= byteCnt + 2'd1;
        asmBytes <= word[23:0];
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.uart_rx_data;
`endif
      end
      case (state)
        S_LEN: begin
          if (pop && byteCnt == 2'd3) begin
            wordLen <= word;
            wordIdx <= '0;
            state   <= (word == '0) ? POST_DATA : S_DATA;
          end
        end
        S_DATA: begin
          if (pop && byteCnt == 2'd3) begin
            imemWeR   <= 1'b1;
            imemAddrR <= wordIdx[ADDR_W-1:0];
            imemDiR   <= word;
            wordIdx   <= wordIdx + 32'd1;
            if (wordIdx == wordLen - 32'd1) state <= POST_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (pop) begin
            csumOk <= (bus.uart_rx_data == csum);
            state  <= S_ACK;
          end
        end
`endif
        // ackArm spaces the push at least one cycle behind the final imem write.
        S_ACK: begin
          if (!ackArm) begin
            ackArm <= 1'b1;
          end else if (!bus.full) begin
            ackArm <= 1'b0;
            if (ackOk) begin
              state    <= S_RUN;
              cpuRstnR <= 1'b1;
              doneR    <= 1'b1;
            end else begin
              state <= S_LEN;
`ifdef LOADER_CHECKSUM_EN
              csum  <= '0;
`endif
            end
          end
        end
        S_RUN:   ;
        default: state <= S_LEN;
      endcase
    end
  end

  always_comb begin
    if (running) begin
      bus.imem_we      = bus.cpu_imem_we;
      bus.imem_waddr   = bus.cpu_imem_waddr;
      bus.imem_di      = bus.cpu_imem_di;
      bus.uart_rd_en   = bus.cpu_uart_rd_en;
      bus.uart_wr_en   = bus.cpu_uart_wr_en;
      bus.uart_tx_data = bus.cpu_uart_tx_data;
    end else begin
      bus.imem_we      = imemWeR;
      bus.imem_waddr   = imemAddrR;
      bus.imem_di      = imemDiR;
      bus.uart_rd_en   = pop;
      bus.uart_wr_en   = (state == S_ACK) && ackArm && !bus.full;
      bus.uart_tx_data = (state == S_ACK) ? (ackOk ? ACK_BYTE : NAK_BYTE) : '0;
    end
  end

  assign bus.cpu_rstn = cpuRstnR;
  assign bus.done     = doneR;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: table vectors, corner sequences and
// random images checked against an image-level reference model.
`timescale 1ns/1ps
module tb_boot_loader_ctrl;
  localparam int unsigned AW = 10;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int unsigned   cyc;
  } wr_t;
  typedef struct {
    int unsigned   n;
    logic [31:0]   w0;
    logic [31:0]   w1;
    bit            stall;
    int unsigned   fullHold;
    int unsigned   expWrites;
    logic [AW-1:0] expLastAddr;
    logic [31:0]   expLastData;
    logic [7:0]    expTx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boot_loader_ctrl_if #(.ADDR_W(AW)) bus ();

  boot_loader_ctrl #(.ADDR_W(AW), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned nVec = 0;
  int unsigned nBad = 0;
  int unsigned cyc = 0;
  bq_t         q;
  wr_t         wrQ[$];
  wr_t         expQ[$];
  logic [7:0]  txQ[$];
  int unsigned popCyc[$];
  logic [7:0]  expTx;
  bit          expRelease;
  bit          altStall = 0;
  int unsigned holdLeft = 0;
  int unsigned pops, rdViol, fullViol, pushCyc, lastWeCyc, rstnCyc;
  bit          rstnSeen, finished;
  vec_t        tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 unit later, then advance.
  task automatic tick();
    bus.empty        = (q.size() == 0) || (altStall && cyc[0]);
    bus.uart_rx_data = (q.size() != 0) ? q[0] : 8'h00;
    bus.full         = (holdLeft != 0);
    #1;
    if (!bus.done) begin
      if (bus.uart_rd_en) begin
        if (bus.empty) rdViol++;
        else begin
          void'(q.pop_front());
          popCyc.push_back(cyc);
          pops++;
        end
      end
      if (bus.imem_we) begin
        wrQ.push_back('{bus.imem_waddr, bus.imem_di, cyc});
        lastWeCyc = cyc;
      end
      if (bus.uart_wr_en) begin
        if (bus.full) fullViol++;
        txQ.push_back(bus.uart_tx_data);
        pushCyc = cyc;
      end
    end
    if (bus.cpu_rstn && !rstnSeen) begin
      rstnSeen = 1;
      rstnCyc  = cyc;
    end
    if (q.size() == 0 && holdLeft != 0) holdLeft--;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic cpuActive();
    bus.cpu_imem_we      = 1'b1;
    bus.cpu_imem_waddr   = '1;
    bus.cpu_imem_di      = 32'hFFFF_FFFF;
    bus.cpu_uart_rd_en   = 1'b1;
    bus.cpu_uart_wr_en   = 1'b1;
    bus.cpu_uart_tx_data = 8'h3C;
  endtask

  task automatic doReset();
    cpuActive();
    q.delete();
    holdLeft = 0;
    altStall = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic checkResetVals(input string nm);
    bus.empty = 1'b1;
    bus.full  = 1'b0;
    #1;
    chk(nm, {bus.imem_we, bus.imem_waddr, bus.imem_di, bus.uart_rd_en, bus.uart_wr_en,
             bus.uart_tx_data, bus.cpu_rstn, bus.done}, '0);
  endtask

  function automatic bq_t makeImage(input int unsigned n, input logic [31:0] w[$]);
    bq_t b;
    logic [7:0] x;
    logic [31:0] nv;
    nv = n;
    for (int unsigned k = 0; k < 4; k++) b.push_back(nv[31 - 8*k -: 8]);
    for (int unsigned i = 0; i < n; i++)
      for (int unsigned k = 0; k < 4; k++) b.push_back(w[i][31 - 8*k -: 8]);
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
`else
    x = 8'h00;
`endif
    return b;
  endfunction

  // Reference: the image says N words go to addresses i mod 2^AW, then ACK/NAK.
  task automatic buildExpect(input bq_t img);
    int unsigned n;
    logic [7:0]  x;
    wr_t         e;
    expQ.delete();
    n = {img[0], img[1], img[2], img[3]};
    x = img[0] ^ img[1] ^ img[2] ^ img[3];
    for (int unsigned i = 0; i < n; i++) begin
      e.addr = AW'(i % (32'd1 << AW));
      e.data = {img[4+4*i], img[5+4*i], img[6+4*i], img[7+4*i]};
      e.cyc  = 0;
      x ^= img[4+4*i] ^ img[5+4*i] ^ img[6+4*i] ^ img[7+4*i];
      expQ.push_back(e);
    end
`ifdef LOADER_CHECKSUM_EN
    expTx = (img[4+4*n] == x) ? 8'hAA : 8'h55;
`else
    expTx = 8'hAA;
`endif
    expRelease = (expTx == 8'hAA);
  endtask

  task automatic clearRecords();
    wrQ.delete(); txQ.delete(); popCyc.delete();
    pops = 0; rdViol = 0; fullViol = 0; pushCyc = 0; lastWeCyc = 0; rstnCyc = 0;
    rstnSeen = 0;
  endtask

  task automatic runLoad(input bq_t img, input bit stall, input int unsigned fullHold);
    int unsigned budget;
    clearRecords();
    buildExpect(img);
    q = img;
    altStall = stall;
    holdLeft = fullHold;
    finished = 0;
    budget = 8 * img.size() + fullHold + 40;
    for (int unsigned k = 0; k < budget; k++) begin
      tick();
      if (txQ.size() != 0 && q.size() == 0) begin
        finished = 1;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic checkLoad(input string nm);
    chk({nm, "_finished"}, finished, 1);
    chk({nm, "_nwrites"}, wrQ.size(), expQ.size());
    for (int unsigned i = 0; i < wrQ.size() && i < expQ.size(); i++) begin
      chk($sformatf("%s_wr%0d", nm, i), {wrQ[i].addr, wrQ[i].data}, {expQ[i].addr, expQ[i].data});
      if (7 + 4*i < popCyc.size())
        chk($sformatf("%s_wrlat%0d", nm, i), wrQ[i].cyc, popCyc[7 + 4*i] + 1);
    end
    chk({nm, "_ntx"}, txQ.size(), 1);
    if (txQ.size() != 0) chk({nm, "_txbyte"}, txQ[0], expTx);
    if (expQ.size() != 0) chk({nm, "_ack_after_we"}, pushCyc > lastWeCyc, 1);
    chk({nm, "_release"}, {bus.cpu_rstn, bus.done}, {expRelease, expRelease});
    if (expRelease) chk({nm, "_rstn_lat"}, rstnCyc, pushCyc + 1);
    chk({nm, "_rd_when_empty"}, rdViol, 0);
    chk({nm, "_wr_when_full"}, fullViol, 0);
  endtask

  initial begin
    logic [31:0] w[$];
    bq_t         img;
    int unsigned n, guard;
    logic [7:0]  ci;

    tbl[0] = '{2, 32'h0000_0013, 32'hDEAD_BEEF, 0, 0,  2, 10'd1, 32'hDEAD_BEEF, 8'hAA};
    tbl[1] = '{0, 32'h0,         32'h0,         0, 0,  0, 10'd0, 32'h0,         8'hAA};
    tbl[2] = '{1, 32'h1234_5678, 32'h0,         1, 0,  1, 10'd0, 32'h1234_5678, 8'hAA};
    tbl[3] = '{1, 32'h00C0_FFEE, 32'h0,         0, 12, 1, 10'd0, 32'h00C0_FFEE, 8'hAA};

    rst = 1'b1;
    bus.empty = 1'b1;
    bus.full  = 1'b0;
    bus.uart_rx_data = 8'h00;
    cpuActive();
    clearRecords();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    checkResetVals("reset_state");

    foreach (tbl[i]) begin
      doReset();
      w = '{tbl[i].w0, tbl[i].w1};
      runLoad(makeImage(tbl[i].n, w), tbl[i].stall, tbl[i].fullHold);
      checkLoad($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_writes", i), wrQ.size(), tbl[i].expWrites);
      if (tbl[i].expWrites != 0 && wrQ.size() != 0)
        chk($sformatf("tbl%0d_last", i), {wrQ[$].addr, wrQ[$].data},
            {tbl[i].expLastAddr, tbl[i].expLastData});
      if (txQ.size() != 0) chk($sformatf("tbl%0d_tx", i), txQ[0], tbl[i].expTx);
    end

    // Core owns the ports once released.
    for (int unsigned k = 0; k < 6; k++) begin
      bus.cpu_imem_we      = 1'($urandom);
      bus.cpu_imem_waddr   = AW'($urandom);
      bus.cpu_imem_di      = $urandom;
      bus.cpu_uart_rd_en   = 1'($urandom);
      bus.cpu_uart_wr_en   = 1'($urandom);
      bus.cpu_uart_tx_data = 8'($urandom);
      bus.empty            = 1'($urandom);
      bus.full             = 1'($urandom);
      #1;
      chk($sformatf("passthru%0d", k),
          {bus.imem_we, bus.imem_waddr, bus.imem_di, bus.uart_rd_en, bus.uart_wr_en, bus.uart_tx_data},
          {bus.cpu_imem_we, bus.cpu_imem_waddr, bus.cpu_imem_di, bus.cpu_uart_rd_en,
           bus.cpu_uart_wr_en, bus.cpu_uart_tx_data});
      @(posedge clk);
      @(negedge clk);
    end
    doReset();
    checkResetVals("rst_in_run");

    // Reset after 6 data bytes of a 2-word load, then resend.
    w = '{32'h0000_0013, 32'hDEAD_BEEF};
    img = makeImage(2, w);
    clearRecords();
    q = img;
    guard = 0;
    while (pops < 10 && guard < 200) begin
      tick();
      guard++;
    end
    chk("midrst_reached", pops, 10);
    chk("midrst_prewrites", wrQ.size(), 1);
    doReset();
    checkResetVals("midrst_outputs");
    runLoad(img, 0, 0);
    checkLoad("midrst_resend");

    // Address wrap: 1026 words into 1024 locations.
    doReset();
    w.delete();
    for (int unsigned i = 0; i < 1026; i++) w.push_back($urandom);
    runLoad(makeImage(1026, w), 0, 0);
    checkLoad("wrap");

    for (int unsigned r = 0; r < 6; r++) begin
      doReset();
      n = $urandom_range(0, 4);
      w.delete();
      for (int unsigned i = 0; i < n; i++) w.push_back($urandom);
      runLoad(makeImage(n, w), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
      checkLoad($sformatf("rnd%0d", r));
    end

`ifdef LOADER_CHECKSUM_EN
    doReset();
    img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    runLoad(img, 0, 0);
    checkLoad("csum_bad");
    if (txQ.size() != 0) chk("csum_bad_nak", txQ[0], 8'h55);
    ci = 8'h01;
    img[8] = ci;
    runLoad(img, 0, 0);
    checkLoad("csum_good");
`else
    ci = 8'h00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
